// File: rtl/ex_div_unit_if.sv
// rtl/ex_div_unit_if.sv - EX-stage divider request and HI/LO write bus
interface ex_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              div_start;
  logic              div_signed;
  logic [DATA_W-1:0] div_dividend;
  logic [DATA_W-1:0] div_divisor;
  logic              div_cancel;
  logic              div_busy;
  logic              div_done;
  logic              div_stall_req;
  logic              ex_is_write_hi;
  logic              ex_is_write_lo;
  logic [DATA_W-1:0] ex_write_hi_value;
  logic [DATA_W-1:0] ex_write_lo_value;

  // EX pipeline side: issues operations, consumes the HI/LO write bus
  modport master (
    output div_start, div_signed, div_dividend, div_divisor, div_cancel,
    input  div_busy, div_done, div_stall_req,
    input  ex_is_write_hi, ex_is_write_lo, ex_write_hi_value, ex_write_lo_value
  );

  // Divider side
  modport slave (
    input  div_start, div_signed, div_dividend, div_divisor, div_cancel,
    output div_busy, div_done, div_stall_req,
    output ex_is_write_hi, ex_is_write_lo, ex_write_hi_value, ex_write_lo_value
  );
endinterface

// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - radix-2 restoring DIV/DIVU unit driving the EX HI/LO bus (option: DIV_SHORTCUT_EN)
module ex_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic         clk,
  input  logic         resetn,
  ex_div_unit_if.slave div_if
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;

  logic              a_neg, b_neg, b_zero;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W:0]   shifted;
  logic              take_sub;
  logic [DATA_W-1:0] step_rem, step_quo;

  // Operand conditioning and one restoring step from the current remainder/quotient
  always_comb begin
    a_neg  = div_if.div_signed & div_if.div_dividend[DATA_W-1];
    b_neg  = div_if.div_signed & div_if.div_divisor[DATA_W-1];
    b_zero = (div_if.div_divisor == '0);
    // A zero divisor keeps the raw dividend so the 32 steps return it unchanged in HI
    a_abs  = (a_neg && !b_zero) ? ('0 - div_if.div_dividend) : div_if.div_dividend;
    b_abs  = b_neg ? ('0 - div_if.div_divisor) : div_if.div_divisor;

    shifted  = {rem_q, quo_q[DATA_W-1]};
    take_sub = (shifted >= {1'b0, dvs_q});
    step_rem = take_sub ? (shifted[DATA_W-1:0] - dvs_q) : shifted[DATA_W-1:0];
    step_quo = {quo_q[DATA_W-2:0], take_sub};
  end

  // Next-state and datapath update for the divider FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    if (div_if.div_cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_if.div_start) begin
            state_d   = S_CALC;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = a_abs;
            dvs_d     = b_abs;
            neg_quo_d = div_if.div_signed &
                        (div_if.div_dividend[DATA_W-1] ^ div_if.div_divisor[DATA_W-1]);
            neg_rem_d = a_neg;
`ifdef DIV_SHORTCUT_EN
            if (b_zero) begin
              state_d = S_FINISH;
              quo_d   = '1;
              rem_d   = div_if.div_dividend;
            end else if (a_abs < b_abs) begin
              state_d = S_FINISH;
              quo_d   = '0;
              rem_d   = a_abs;
            end
`endif
          end
        end
        S_CALC: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = S_FINISH;
          end
        end
        S_FINISH: begin
          // Divide-by-zero results are already in final form, so no sign fix-up
          lo_d    = (neg_quo_q && dvs_q != '0) ? ('0 - quo_q) : quo_q;
          hi_d    = (neg_rem_q && dvs_q != '0) ? ('0 - rem_q) : rem_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign div_if.div_busy          = (state_q != S_IDLE);
  assign div_if.div_done          = done_q;
  assign div_if.div_stall_req     = div_if.div_start & ~done_q;
  assign div_if.ex_is_write_hi    = done_q;
  assign div_if.ex_is_write_lo    = done_q;
  assign div_if.ex_write_hi_value = hi_q;
  assign div_if.ex_write_lo_value = lo_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - scoreboard bench for ex_div_unit against an arithmetic reference
module tb_ex_div_unit;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ex_div_unit_if #(.DATA_W(32)) dif ();

  ex_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .div_if (dif)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain truncating division in 64-bit arithmetic
  task automatic model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint sa, sb, q, r, aa, ab;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
    aa  = (sa < 0) ? -sa : sa;
    ab  = (sb < 0) ? -sb : sb;
    lat = 34;
`ifdef DIV_SHORTCUT_EN
    if (b == 32'd0 || aa < ab) lat = 2;
`endif
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (dif.div_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard, required none (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("lo_value", dif.ex_write_lo_value, mon_e.lo);
        chk("hi_value", dif.ex_write_hi_value, mon_e.hi);
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("we_hi_lo", {30'b0, dif.ex_is_write_hi, dif.ex_is_write_lo}, 32'd3);
      end
    end
  end

  task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo;
    int          lat;
    bit          seen;
    exp_t        e;
    model(sgn, a, b, ehi, elo, lat);
    @(posedge clk);
    #1;
    dif.div_signed   = sgn;
    dif.div_dividend = a;
    dif.div_divisor  = b;
    dif.div_start    = 1'b1;
    e.hi  = ehi;
    e.lo  = elo;
    e.cyc = cyc + lat;
    sb_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (dif.div_done === 1'b1) begin
        seen = 1'b1;
        chk("stall_busy_done", {30'b0, dif.div_stall_req, dif.div_busy}, 32'd1);
      end else begin
        chk("stall_busy", {30'b0, dif.div_stall_req, dif.div_busy}, (i == 0) ? 32'd2 : 32'd3);
        if (i >= 1) begin
          dif.div_signed   = 1'($urandom_range(0, 1));
          dif.div_dividend = $urandom;
          dif.div_divisor  = $urandom;
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in 60 cycles, required done");
      void'(sb_q.pop_back());
    end
    @(posedge clk);
    #1;
    dif.div_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    int          mode;
    int          k;
    resetn           = 1'b0;
    dif.div_start    = 1'b0;
    dif.div_signed   = 1'b0;
    dif.div_dividend = '0;
    dif.div_divisor  = '0;
    dif.div_cancel   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy_done", {30'b0, dif.div_busy, dif.div_done}, 32'd0);
    chk("reset_we", {30'b0, dif.ex_is_write_hi, dif.ex_is_write_lo}, 32'd0);
    chk("reset_hi", dif.ex_write_hi_value, 32'd0);
    chk("reset_lo", dif.ex_write_lo_value, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    do_op(1'b0, 32'd100, 32'd7);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(1'b0, 32'h1234_5678, 32'd0);
    do_op(1'b1, 32'hFFFF_FF00, 32'd0);
    do_op(1'b0, 32'd3, 32'd10);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1);

    // Cancel mid-calculation: no result, then a clean new operation
    @(posedge clk);
    #1;
    dif.div_signed   = 1'b0;
    dif.div_dividend = 32'd50;
    dif.div_divisor  = 32'd5;
    dif.div_start    = 1'b1;
    k = cyc;
    while (cyc < k + 11) begin
      @(posedge clk);
      #1;
    end
    dif.div_cancel = 1'b1;
    @(posedge clk);
    #1;
    dif.div_cancel = 1'b0;
    dif.div_start  = 1'b0;
    chk("cancel_busy", {31'b0, dif.div_busy}, 32'd0);
    repeat (40) @(negedge clk);
    do_op(1'b0, 32'd9, 32'd3);

    // Asynchronous reset in the middle of a calculation
    @(posedge clk);
    #1;
    dif.div_signed   = 1'b0;
    dif.div_dividend = 32'd77;
    dif.div_divisor  = 32'd3;
    dif.div_start    = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("areset_busy_done", {30'b0, dif.div_busy, dif.div_done}, 32'd0);
    chk("areset_we", {30'b0, dif.ex_is_write_hi, dif.ex_is_write_lo}, 32'd0);
    chk("areset_hi", dif.ex_write_hi_value, 32'd0);
    chk("areset_lo", dif.ex_write_lo_value, 32'd0);
    dif.div_start = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    do_op(1'b0, 32'd1, 32'd1);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 3);
      ra   = $urandom;
      rb   = $urandom;
      case (mode)
        0: rb = $urandom_range(0, 15);
        1: rb = $urandom >> $urandom_range(0, 31);
        2: ra = $urandom_range(0, 100);
        default: ;
      endcase
      do_op(1'($urandom_range(0, 1)), ra, rb);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
Iterative radix-2 restoring divider in the EX stage. It executes DIV/DIVU and drives the EX-stage HI/LO write bus: quotient goes to LO, remainder goes to HI. The HI/LO forwarding logic consumes this bus directly. While a division is in flight, it raises a stall request that freezes IF/ID/EX.

Parameters:
DATA_W, 32, operand/result width (only 32 is supported)
CNT_W, 6, iteration counter width; must hold DATA_W

Ports:
clk  input  1  core clock, rising edge
resetn  input  1  asynchronous active-low reset
div_start  input  1  EX holds a DIV/DIVU; stays high until div_done
div_signed  input  1  1=DIV, 0=DIVU; sampled with div_start in IDLE
div_dividend  input  32  rs value; sampled at the accept edge
div_divisor  input  32  rt value; sampled at the accept edge
div_cancel  input  1  flush (exception/eret); aborts any operation
div_busy  output  1  state != IDLE
div_done  output  1  one-cycle result-valid pulse
div_stall_req  output  1  pipeline stall request
ex_is_write_hi  output  1  equals div_done
ex_is_write_lo  output  1  equals div_done
ex_write_hi_value  output  32  remainder
ex_write_lo_value  output  32  quotient

Behaviour:
- Reset (async, resetn=0): state=IDLE, counter=0, all internal registers 0. div_busy=0, div_done=0, ex_is_write_hi/lo=0, ex_write_hi/lo_value=0.
- States: IDLE, CALC, FINISH, DONE.
- IDLE -> CALC when div_start=1 and div_cancel=0 (accept edge E0).
  - At E0, latch |dividend| and |divisor|. Absolute values are taken only when div_signed=1; 0x80000000 stays 0x80000000 as an unsigned value.
  - At E0, also latch sign_q = sign(dividend) XOR sign(divisor), latch sign_r = sign(dividend), and set counter=0.
- CALC: one restoring step per cycle, MSB first.
  - Shift {rem, quo} left 1. Trial-subtract the divisor (33-bit compare). If the result is non-negative, keep it and set the quotient LSB.
  - counter increments each step. After the step with counter=31 (edge E32), go to FINISH.
- FINISH (edge E33): register the sign-corrected results, go to DONE.
  - Quotient is negated if signed and sign_q=1.
  - Remainder is negated if signed and sign_r=1.
- DONE: div_done=1 for exactly one cycle (the cycle between E33 and E34), then IDLE at E34.
  - Result values stay held on ex_write_hi/lo_value until the next accept.
  - The write enables are 1 only in DONE.
- div_stall_req = div_start & ~div_done (combinational). The instruction stays in EX through DONE and advances at E34.
- A new div_start is only accepted in IDLE. A start seen in the cycle after DONE begins a new operation; EX has advanced by then, so this is a new instruction.
- div_cancel=1 in any state: IDLE at the next edge, no div_done. cancel beats start in the same cycle.
- Divisor = 0: run the normal 32 steps and apply no sign correction. Result: LO=0xFFFFFFFF, HI=dividend (raw input value). Latency is unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000, no trap.
- div_signed, dividend and divisor changing after E0 have no effect.

Optional Feature:
DIV_SHORTCUT_EN
- Defined: at E0, if |dividend| < |divisor| (divisor nonzero), go straight to FINISH with quo=0, rem=|dividend|. Sign correction still applies, so HI=dividend and LO=0. div_done falls between E1 and E2.
  - If divisor=0, go straight to FINISH with LO=0xFFFFFFFF, HI=dividend.
  - All other operands take the full 32 steps.
- Undefined: every operation takes the fixed 34-cycle path.

Test Plan:
- DIVU 100/7, start held -> div_done exactly once, in the cycle after E33; LO=14, HI=2; div_stall_req=1 from the start cycle through the cycle before done, 0 in the done cycle.
- DIV -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIV 7/-2 -> LO=-3, HI=1.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 0x12345678/0 -> LO=0xFFFFFFFF, HI=0x12345678.
- Start DIVU 50/5, assert div_cancel at E10 -> IDLE at E11, no div_done, div_busy=0; a new DIVU 9/3 then yields LO=3, HI=0.
- resetn low during CALC (async, mid-cycle) -> outputs immediately 0, state IDLE; after release, DIVU 1/1 gives LO=1, HI=0.
- With DIV_SHORTCUT_EN: DIVU 3/10 -> done between E1 and E2, LO=0, HI=3. Without the macro, same operands -> done at the E33/E34 cycle, same values.
